mcpu_core: RTL and testbench



---
 rtl/mcpu_core_if.sv | 16 +
 rtl/mcpu_core.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mcpu_core.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_core_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mcpu_core_if : program-load bus into the mcpu_core RAM
// Rev 1.0
// ------------------------------------------------------------------
interface mcpu_core_if #(
   parameter int AW = 8
);
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [7:0]    prog_data;

   modport master (output prog_we, prog_addr, prog_data);
   modport slave  (input  prog_we, prog_addr, prog_data);
endinterface
`default_nettype wire

// File: rtl/mcpu_core.sv
`default_nettype none
// ------------------------------------------------------------------
// mcpu_core : 8-bit CPU with key interrupts and an 8x8 LED matrix
// Rev 1.0
// ------------------------------------------------------------------
module mcpu_core #(
   parameter int AW       = 8,
   parameter int NKEYS    = 4,
   parameter int DIV_FAST = 16,
   parameter int DIV_SLOW = 21,
   parameter int SCAN     = 13
) (
   input  wire              clk,
   input  wire              rst,
   input  wire              mode,
   input  wire [NKEYS-1:0]  btn,
   mcpu_core_if.slave       prog,
   output logic [7:0]       col,
   output logic [7:0]       row,
   output logic             low,
   output logic [5:0]       leds
);

   localparam int c_div_max = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
   localparam int c_cw      = (c_div_max > SCAN + 3) ? c_div_max : SCAN + 3;

   typedef enum logic [1:0] {
      S_EXEC = 2'd0,
      S_ARG  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   logic [c_cw-1:0]  r_cnt;
   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_reg [8];
   logic [7:0]       r_vr  [8];
   logic             r_c;
   logic             r_ie;
   logic [AW-1:0]    r_ipc;
   logic [NKEYS-1:0] r_pend;
   logic [NKEYS-1:0] r_btn_q;
   logic [7:0]       r_op;
   logic [7:0]       r_mem [2**AW];

   logic             w_step;
   logic [AW-1:0]    w_pc;
   logic [AW-1:0]    w_pc_inc;
   logic [7:0]       w_pc_inc8;
   logic [7:0]       w_byte;
   logic [7:0]       w_ld;
   logic [2:0]       w_s;
   logic [2:0]       w_d;
   logic [7:0]       w_rs;
   logic [7:0]       w_ars;
   logic [8:0]       w_sum;
   logic [NKEYS-1:0] w_press;
   logic [NKEYS-1:0] w_pend_all;
   logic [NKEYS-1:0] w_irq_hot;
   logic [NKEYS-1:0] w_irq_clr;
   logic [2:0]       w_irq_k;
   logic [7:0]       w_vec;
   logic [2:0]       w_idx;

   logic [7:0]       w_pc_nxt;
   logic             w_we;
   logic [2:0]       w_widx;
   logic [7:0]       w_wdata;
   logic             w_vwe;
   logic [2:0]       w_vidx;
   logic             w_c_nxt;
   logic             w_ie_nxt;
   logic             w_ipc_we;
   logic             w_mwe;
   logic             w_op_we;

   // Step pulse: low DIV bits of the free-running counter all ones
   assign w_step = (mode ? (&r_cnt[DIV_SLOW-1:0]) : (&r_cnt[DIV_FAST-1:0]))
                   & ~prog.prog_we;

   assign w_pc      = r_reg[7][AW-1:0];
   assign w_pc_inc  = w_pc + AW'(1);
   assign w_pc_inc8 = 8'(w_pc_inc);
   assign w_byte    = r_mem[w_pc];
   assign w_ld      = r_mem[w_byte[AW-1:0]];
   assign w_s       = w_byte[2:0];
   assign w_d       = w_byte[5:3];
   assign w_rs      = r_reg[w_s];
   assign w_ars     = r_reg[r_op[2:0]];
   assign w_sum     = {1'b0, r_reg[0]} + {1'b0, w_rs};

   // A press seen on this very step is already eligible for service
   assign w_press    = r_btn_q & ~btn;
   assign w_pend_all = r_pend | w_press;
   assign w_irq_hot  = w_pend_all & (~w_pend_all + NKEYS'(1));

   always_comb begin
      w_irq_k = 3'd0;
      for (int k = 0; k < NKEYS; k++) begin
         if (w_irq_hot[k]) w_irq_k = 3'(k);
      end
   end

   assign w_vec = 8'd2 + {4'd0, w_irq_k, 1'b0};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_reg[7];
      w_we        = 1'b0;
      w_widx      = 3'd0;
      w_wdata     = 8'd0;
      w_vwe       = 1'b0;
      w_vidx      = 3'd0;
      w_c_nxt     = r_c;
      w_ie_nxt    = r_ie;
      w_ipc_we    = 1'b0;
      w_mwe       = 1'b0;
      w_op_we     = 1'b0;
      w_irq_clr   = '0;

      unique case (r_state)
         S_ARG: begin
            w_state_nxt = S_EXEC;
            w_pc_nxt    = w_pc_inc8;
            if (r_op[7:3] == 5'b11100) begin
               w_we    = 1'b1;
               w_widx  = r_op[2:0];
               w_wdata = w_byte;
            end else if (r_op[7:3] == 5'b11101) begin
               w_we    = 1'b1;
               w_widx  = r_op[2:0];
               w_wdata = w_ld;
            end else if (r_op[7:3] == 5'b11110) begin
               w_mwe = 1'b1;
            end else begin
               case (r_op)
                  8'hC0: begin
                     w_pc_nxt = r_c ? w_pc_inc8 : 8'(w_byte[AW-1:0]);
                     w_c_nxt  = 1'b0;
                  end
                  8'hD0: w_pc_nxt = 8'(w_byte[AW-1:0]);
                  8'hC2: begin
                     w_we     = 1'b1;
                     w_widx   = 3'd4;
                     w_wdata  = w_pc_inc8;
                     w_pc_nxt = 8'(w_byte[AW-1:0]);
                  end
                  default: ;
               endcase
            end
         end
         default: begin
            if (r_ie && (|w_pend_all)) begin
               w_ipc_we    = 1'b1;
               w_pc_nxt    = w_vec;
               w_ie_nxt    = 1'b0;
               w_irq_clr   = w_irq_hot;
               w_state_nxt = S_EXEC;
            end else if (r_state == S_EXEC) begin
               w_pc_nxt = w_pc_inc8;
               unique case (w_byte[7:6])
                  2'b00: begin
                     w_we    = 1'b1;
                     w_widx  = w_d;
                     w_wdata = w_rs;
                  end
                  2'b01: begin
                     w_we   = 1'b1;
                     w_widx = w_s;
                     unique case (w_byte[5:3])
                        3'd0: begin
                           w_widx  = 3'd0;
                           w_wdata = w_sum[7:0];
                           w_c_nxt = w_sum[8];
                        end
                        3'd1: begin
                           w_widx  = 3'd0;
                           w_wdata = r_reg[0] | w_rs;
                        end
                        3'd2: begin
                           w_widx  = 3'd0;
                           w_wdata = r_reg[0] & w_rs;
                        end
                        3'd3: begin
                           w_widx  = 3'd0;
                           w_wdata = r_reg[0] ^ w_rs;
                        end
                        3'd4: begin
                           w_wdata = w_rs + 8'd1;
                           w_c_nxt = (w_rs == 8'hFF);
                        end
                        3'd5: w_wdata = ~w_rs;
                        3'd6: w_wdata = {w_rs[0], w_rs[7:1]};
                        default: w_wdata = {w_rs[6:0], w_rs[7]};
                     endcase
                  end
                  2'b10: begin
                     w_vwe  = 1'b1;
                     w_vidx = w_d;
                  end
                  default: begin
                     if (w_byte[5]) begin
                        if (w_byte[4:3] != 2'b11) begin
                           w_state_nxt = S_ARG;
                           w_op_we     = 1'b1;
                        end
                     end else begin
                        case (w_byte)
                           8'hC0, 8'hD0, 8'hC2: begin
                              w_state_nxt = S_ARG;
                              w_op_we     = 1'b1;
                           end
                           8'hD2: w_pc_nxt = 8'(r_reg[4][AW-1:0]);
                           8'hC3: begin
                              w_pc_nxt = 8'(r_ipc);
                              w_ie_nxt = 1'b1;
                           end
                           8'hC1: w_ie_nxt = 1'b1;
                           8'hD1: w_ie_nxt = 1'b0;
                           8'hD3: w_state_nxt = S_HALT;
                           default: ;
                        endcase
                     end
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_EXEC;
      end else if (w_step) begin
         r_state <= w_state_nxt;
      end
   end

   // Later assignments win: explicit register writes override the PC
   // update, and the key snapshot always overrides R5.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         for (int i = 0; i < 8; i++) begin
            r_reg[i] <= 8'd0;
            r_vr[i]  <= 8'd0;
         end
         r_c     <= 1'b0;
         r_ie    <= 1'b0;
         r_ipc   <= '0;
         r_pend  <= '0;
         r_btn_q <= '1;
         r_op    <= 8'd0;
      end else begin
         r_cnt <= r_cnt + c_cw'(1);
         if (w_step) begin
            r_reg[7] <= w_pc_nxt;
            if (w_we) r_reg[w_widx] <= w_wdata;
            r_reg[5] <= {{(8-NKEYS){1'b0}}, ~btn};
            if (w_vwe) r_vr[w_vidx] <= w_rs;
            r_c     <= w_c_nxt;
            r_ie    <= w_ie_nxt;
            if (w_ipc_we) r_ipc <= w_pc;
            r_pend  <= w_pend_all & ~w_irq_clr;
            r_btn_q <= btn;
            if (w_op_we) r_op <= w_byte;
         end
      end
   end

   // RAM has no reset so a loaded program survives rst
   always_ff @(posedge clk) begin
      if (prog.prog_we) begin
         r_mem[prog.prog_addr] <= prog.prog_data;
      end else if (w_step && w_mwe && rst) begin
         r_mem[w_byte[AW-1:0]] <= w_ars;
      end
   end

   assign w_idx = r_cnt[SCAN+2:SCAN];
   assign row   = ~(8'd1 << w_idx);
   assign col   = mode ? r_reg[w_idx] : r_vr[w_idx];
   assign low   = 1'b0;
   assign leds  = {~r_c, ~(r_state == S_HALT), ~r_reg[6][3:0]};

endmodule
`default_nettype wire

// File: tb/tb_mcpu_core.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mcpu_core : directed vector bench for mcpu_core, regs read via the matrix
// Rev 1.0
// ------------------------------------------------------------------
module tb_mcpu_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       mode;
   logic [3:0] btn;
   logic [7:0] col;
   logic [7:0] row;
   logic       low;
   logic [5:0] leds;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] sr   [8];
   logic [7:0] sv   [8];
   logic [7:0] srow [8];
   logic [5:0] sled;

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] e0;
      logic [7:0] e1;
      logic       ec;
   } vec_t;

   vec_t vecs [11];

   mcpu_core_if #(.AW(8)) pif ();

   mcpu_core #(
      .AW       (8),
      .NKEYS    (4),
      .DIV_FAST (4),
      .DIV_SLOW (4),
      .SCAN     (0)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .btn  (btn),
      .prog (pif),
      .col  (col),
      .row  (row),
      .low  (low),
      .leds (leds)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      pif.prog_we   = 1'b1;
      pif.prog_addr = a;
      pif.prog_data = d;
      @(posedge clk);
      #1;
      pif.prog_we   = 1'b0;
   endtask

   task automatic begin_test();
      rst = 1'b0;
      btn = 4'hF;
      #1;
      for (int i = 0; i < 256; i++) wr(8'(i), 8'hFF);
   endtask

   task automatic sample(input int j);
      mode = 1'b1;
      #1;
      srow[j] = row;
      sr[j]   = col;
      sled    = leds;
      mode = 1'b0;
      #1;
      sv[j] = col;
      mode = 1'b1;
   endtask

   // Leaves the bench one clock before the first step edge
   task automatic start();
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk);
         #1;
         if (k <= 8) sample(k % 8);
      end
   endtask

   task automatic run(input int n);
      for (int s = 0; s < n; s++) begin
         for (int j = 0; j < 16; j++) begin
            @(posedge clk);
            #1;
            if (j < 8) sample(j);
         end
      end
   endtask

   initial begin
      logic [7:0] one;
      one = 8'h01;

      vecs[0]  = '{8'h41, 8'hF0, 8'h20, 8'h10, 8'h20, 1'b1};
      vecs[1]  = '{8'h41, 8'h12, 8'h34, 8'h46, 8'h34, 1'b0};
      vecs[2]  = '{8'h49, 8'hF0, 8'h0F, 8'hFF, 8'h0F, 1'b0};
      vecs[3]  = '{8'h51, 8'h3C, 8'h0F, 8'h0C, 8'h0F, 1'b0};
      vecs[4]  = '{8'h59, 8'hFF, 8'h0F, 8'hF0, 8'h0F, 1'b0};
      vecs[5]  = '{8'h61, 8'h33, 8'hFF, 8'h33, 8'h00, 1'b1};
      vecs[6]  = '{8'h61, 8'h33, 8'h7F, 8'h33, 8'h80, 1'b0};
      vecs[7]  = '{8'h69, 8'h33, 8'hA5, 8'h33, 8'h5A, 1'b0};
      vecs[8]  = '{8'h71, 8'h33, 8'h01, 8'h33, 8'h80, 1'b0};
      vecs[9]  = '{8'h79, 8'h33, 8'h81, 8'h33, 8'h03, 1'b0};
      vecs[10] = '{8'h01, 8'h11, 8'h22, 8'h22, 8'h22, 1'b0};

      rst = 1'b0;
      mode = 1'b1;
      btn = 4'hF;
      pif.prog_we = 1'b0;
      pif.prog_addr = 8'd0;
      pif.prog_data = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_row",  row, 8'hFE);
      chk("rst_col",  col, 8'h00);
      chk("rst_low",  {7'd0, low}, 8'h00);
      chk("rst_leds", {2'd0, leds}, 8'h3F);

      // ALU / MOV vectors: MVI R0,a; MVI R1,b; op
      for (int v = 0; v < 11; v++) begin
         begin_test();
         wr(8'h00, 8'hE0); wr(8'h01, vecs[v].a);
         wr(8'h02, 8'hE1); wr(8'h03, vecs[v].b);
         wr(8'h04, vecs[v].op);
         start();
         run(5);
         chk($sformatf("vec%0d_r0", v), sr[0], vecs[v].e0);
         chk($sformatf("vec%0d_r1", v), sr[1], vecs[v].e1);
         chk($sformatf("vec%0d_led5", v), {7'd0, sled[5]}, {7'd0, ~vecs[v].ec});
         chk($sformatf("vec%0d_pc", v), sr[7], 8'h05);
      end

      // MVI R2,0x40; VPOKE VR6,R2
      begin_test();
      wr(8'h00, 8'hE2); wr(8'h01, 8'h40); wr(8'h02, 8'hB2);
      start();
      run(3);
      chk("vpoke_vr6", sv[6], 8'h40);
      chk("vpoke_r2",  sr[2], 8'h40);
      chk("vpoke_pc",  sr[7], 8'h03);
      for (int j = 0; j < 8; j++) chk($sformatf("scan_row%0d", j), srow[j], ~(one << j));

      // ADD with carry then JNC not taken, then JNC taken
      begin_test();
      wr(8'h00, 8'hE0); wr(8'h01, 8'hF0); wr(8'h02, 8'hE1); wr(8'h03, 8'h20);
      wr(8'h04, 8'h41); wr(8'h05, 8'hC0); wr(8'h06, 8'h30);
      wr(8'h07, 8'hC0); wr(8'h08, 8'h30);
      start();
      run(5);
      chk("add_r0",   sr[0], 8'h10);
      chk("add_led5", {7'd0, sled[5]}, 8'h00);
      run(2);
      chk("jnc_c_pc",   sr[7], 8'h07);
      chk("jnc_c_led5", {7'd0, sled[5]}, 8'h01);
      run(2);
      chk("jnc_nc_pc", sr[7], 8'h30);

      // EI, JMP 0x20, HALT; key1 -> vector 4 (NOP, RETI)
      begin_test();
      wr(8'h00, 8'hC1); wr(8'h01, 8'hD0); wr(8'h02, 8'h20);
      wr(8'h05, 8'hC3); wr(8'h20, 8'hD3);
      start();
      run(4);
      chk("halt_pc",   sr[7], 8'h21);
      chk("halt_led4", {7'd0, sled[4]}, 8'h00);
      run(1);
      chk("halt_stay_pc", sr[7], 8'h21);
      btn = 4'b1101;
      run(1);
      chk("irq1_pc",   sr[7], 8'h04);
      chk("irq1_led4", {7'd0, sled[4]}, 8'h01);
      btn = 4'b1011;
      run(1);
      chk("irq_masked_pc", sr[7], 8'h05);
      run(1);
      chk("reti_pc", sr[7], 8'h21);
      run(1);
      chk("irq2_after_reti_pc", sr[7], 8'h06);
      btn = 4'hF;

      // Two keys pending while ie=0, served lowest first
      begin_test();
      wr(8'h00, 8'hD0); wr(8'h01, 8'h10); wr(8'h02, 8'hC3);
      wr(8'h06, 8'hC3); wr(8'h11, 8'hC1);
      btn = 4'b1010;
      start();
      run(4);
      chk("pri_ei_pc", sr[7], 8'h12);
      run(1);
      chk("pri_k0_pc", sr[7], 8'h02);
      run(1);
      chk("pri_ret0_pc", sr[7], 8'h12);
      run(1);
      chk("pri_k2_pc", sr[7], 8'h06);
      run(1);
      chk("pri_ret2_pc", sr[7], 8'h12);
      run(1);
      chk("pri_done_pc", sr[7], 8'h13);
      btn = 4'hF;

      // CALL 0x40 / RET, INC of 0xFF
      begin_test();
      wr(8'h00, 8'hE3); wr(8'h01, 8'hFF); wr(8'h02, 8'hC2); wr(8'h03, 8'h40);
      wr(8'h04, 8'h63); wr(8'h40, 8'hD2);
      start();
      run(4);
      chk("call_pc", sr[7], 8'h40);
      chk("call_r4", sr[4], 8'h04);
      run(1);
      chk("ret_pc", sr[7], 8'h04);
      run(1);
      chk("inc_r3",   sr[3], 8'h00);
      chk("inc_led5", {7'd0, sled[5]}, 8'h00);
      chk("inc_pc",   sr[7], 8'h05);

      // Reset in the middle of ST's operand step
      begin_test();
      wr(8'h00, 8'hE1); wr(8'h01, 8'h5A); wr(8'h02, 8'hF1); wr(8'h03, 8'h80);
      start();
      run(3);
      rst = 1'b0;
      #1;
      chk("abort_row",  row, 8'hFE);
      chk("abort_leds", {2'd0, leds}, 8'h3F);
      wr(8'h00, 8'hEA); wr(8'h01, 8'h80); wr(8'h02, 8'hE1); wr(8'h03, 8'hD3);
      wr(8'h04, 8'hF1); wr(8'h05, 8'h06);
      start();
      chk("abort_r1", sr[1], 8'h00);
      chk("abort_pc", sr[7], 8'h00);
      run(2);
      chk("abort_ram80", sr[2], 8'hFF);
      run(4);
      chk("selfmod_pc", sr[7], 8'h06);
      run(1);
      chk("selfmod_halt_pc",   sr[7], 8'h07);
      chk("selfmod_halt_led4", {7'd0, sled[4]}, 8'h00);
      btn = 4'b1110;
      run(2);
      chk("halt_noie_pc",   sr[7], 8'h07);
      chk("halt_noie_led4", {7'd0, sled[4]}, 8'h00);
      btn = 4'hF;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
